svm_load_sequencer: RTL and testbench
=====================================

// Module: svm_load_sequencer
// PURPOSE
//  Controller that sequences one classification job through the SVM classifier (fsm_Hand).
//  On go: streams N_COEF signed coefficients from a coefficient ROM on write1/SVMin.
//  Then streams N_FEAT test samples from a feature ROM on write2/datain.
//  Then waits for the classifier's ready, captures result, and reports done/timeout.
//  Replaces bench-driven loading, so the classifier can run from on-chip memories.
// PARAMETERS
//  N_COEF   121   coefficient words per job
//  N_FEAT   11    feature samples per job
//  COEF_W   9     coefficient width, signed
//  FEAT_W   2     feature width, signed
//  TIMEOUT  4096  max cycles in WAIT_RDY before err_timeout
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        asynchronous, active-low reset
//  go            in   1        job request; sampled only in IDLE
//  abort         in   1        synchronous job abort
//  coef_addr     out  7        coefficient ROM address; ROM read latency is 1 cycle
//  coef_data     in   COEF_W   coefficient ROM data
//  feat_addr     out  4        feature ROM address; ROM read latency is 1 cycle
//  feat_data     in   FEAT_W   feature ROM data
//  cls_start     out  1        classifier start
//  write1        out  1        coefficient beat valid
//  svm_out       out  COEF_W   coefficient to classifier (SVMin)
//  write2        out  1        feature beat valid
//  data_out      out  FEAT_W   feature to classifier (datain)
//  cls_ready     in   1        classifier result valid
//  cls_result    in   1        classifier decision
//  busy          out  1        job in progress
//  done          out  1        one-cycle job-complete pulse
//  result_q      out  1        captured decision, held until next capture
//  err_timeout   out  1        sticky; cleared on next accepted go
// BEHAVIOUR
//  Reset (rst=0): state IDLE; every output 0, including addresses and result_q. Reset acts immediately.
//  FSM states: IDLE -> PREF -> LOAD_COEF -> LOAD_FEAT -> WAIT_RDY -> DONE -> IDLE.
//  - IDLE: go=1 starts a job: err_timeout<=0, busy<=1, cls_start<=1, coef_addr<=0, next state PREF.
//  - PREF: one cycle for the first ROM read; coef_addr advances to 1.
//  - LOAD_COEF: write1=1 for exactly N_COEF consecutive cycles.
//      svm_out equals coef[k] on beat k, in order 0..N_COEF-1.
//      feat_addr<=0 on the last coefficient beat, as a prefetch.
//  - LOAD_FEAT: write2=1 for exactly N_FEAT consecutive cycles, on the cycle after the last write1 beat (zero gap).
//      data_out equals feat[k] on beat k. write1 and write2 are never high together.
//  - WAIT_RDY: write1=write2=0; cycle counter runs.
//      cls_ready=1: result_q<=cls_result, next state DONE.
//      Counter reaches TIMEOUT: err_timeout<=1, result_q unchanged, next state DONE.
//  - DONE: done=1 for exactly one cycle; cls_start<=0, busy<=0; next state IDLE.
//  - cls_start stays high from the PREF entry through the last WAIT_RDY cycle.
//  - svm_out/data_out hold their last value when their write strobe is low.
//  - go while busy is ignored (no queuing). go in DONE is ignored. go in IDLE on the cycle after DONE is accepted.
//  - abort=1 in any non-IDLE state: next cycle IDLE with all strobes, cls_start and busy at 0; no done pulse; result_q unchanged.
//      abort takes priority over cls_ready and timeout in the same cycle.
//  - cls_ready outside WAIT_RDY is ignored.
//  - Address counters saturate at their last index; they never wrap within a job.
//  - Job length without stall: 1 + N_COEF + N_FEAT cycles to the end of load, i.e. 133 with default parameters.
// STRUCTURE
//  Shared package svm_pkg: state enum seq_state_t; N_COEF, N_FEAT, COEF_W, FEAT_W; coef_t/feat_t signed typedefs.
//  The classifier and the bench also use svm_pkg.
//  One sub-module, svm_beat_counter: load, enable, terminal-count flag.
//  It is instantiated twice: for the coefficient/feature index and for the timeout counter.
// TESTING
//  1 Reset: rst low mid-LOAD_COEF (beat 50) -> all outputs 0 immediately; go after release restarts from coef[0].
//  2 Nominal job, ROM coef[k]=k-60, feat[k]=k%4-2, classifier model asserts ready 20 cycles after the last write2:
//      write1 for 121 cycles, then write2 for 11 cycles, values in order.
//      With result=1: result_q=1, done pulses once, busy low the next cycle.
//  3 Timeout: TIMEOUT=16, cls_ready held 0 -> err_timeout=1 and done pulses 16 cycles after WAIT_RDY entry.
//      err_timeout clears when the next go is accepted.
//  4 go pulsed during LOAD_FEAT and during DONE -> ignored, beat counts stay 121/11, exactly one done.
//  5 abort on the same cycle as cls_ready=1 with cls_result=1 -> returns to IDLE, no done, result_q keeps its prior value 0.
//  6 Back-to-back: go held high continuously -> second job starts in the IDLE cycle after DONE.
//      Each job produces exactly 121+11 beats, and there is no cycle where write1 and write2 are both high.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared types and sizes for the SVM classifier, its load sequencer and benches.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package svm_pkg;

    localparam int N_COEF  = 121;
    localparam int N_FEAT  = 11;
    localparam int COEF_W  = 9;
    localparam int FEAT_W  = 2;
    localparam int COEF_AW = 7;
    localparam int FEAT_AW = 4;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [FEAT_W-1:0] feat_t;

    typedef enum logic [2:0] {
        IDLE,
        PREF,
        LOAD_COEF,
        LOAD_FEAT,
        WAIT_RDY,
        DONE
    } seq_state_t;

endpackage

// File: rtl/svm_beat_counter.sv
// Loadable down-counter; tc flags that the count has reached zero.
// Latency: load/decrement take effect one cycle after they are sampled.
// Backpressure: none; en gates counting and the count holds at zero.
module svm_beat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load wins over counting; stop at zero so tc stays asserted until reloaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/svm_load_sequencer.sv
// Streams coefficient then feature ROM words into the SVM classifier, then waits for its result.
// Latency: 1 prefetch cycle + N_COEF + N_FEAT beats to end of load; result wait bounded by TIMEOUT.
// Backpressure: none on the beat streams; the classifier must accept one beat per cycle.
module svm_load_sequencer
    import svm_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic                     abort,
    output logic [COEF_AW-1:0]       coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic [FEAT_AW-1:0]       feat_addr,
    input  logic signed [FEAT_W-1:0] feat_data,
    output logic                     cls_start,
    output logic                     write1,
    output logic signed [COEF_W-1:0] svm_out,
    output logic                     write2,
    output logic signed [FEAT_W-1:0] data_out,
    input  logic                     cls_ready,
    input  logic                     cls_result,
    output logic                     busy,
    output logic                     done,
    output logic                     result_q,
    output logic                     err_timeout
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [COEF_AW-1:0] COEF_LAST = COEF_AW'(N_COEF - 1);
    localparam logic [FEAT_AW-1:0] FEAT_LAST = FEAT_AW'(N_FEAT - 1);

    seq_state_t         state;
    logic               beat_load;
    logic               beat_en;
    logic               beat_tc;
    logic [COEF_AW-1:0] beat_init;
    logic               to_load;
    logic               to_en;
    logic               to_tc;
    coef_t              svm_hold;
    feat_t              feat_hold;

    // One counter paces both beat streams: loaded with N_COEF-1 in PREF, then N_FEAT-1 on the last coef beat.
    always_comb begin
        beat_load = (state == PREF) || ((state == LOAD_COEF) && beat_tc);
        beat_init = (state == PREF) ? COEF_AW'(N_COEF - 1) : COEF_AW'(N_FEAT - 1);
        beat_en   = (state == LOAD_COEF) || (state == LOAD_FEAT);
        to_load   = (state == LOAD_FEAT) && beat_tc;
        to_en     = (state == WAIT_RDY);
    end

    svm_beat_counter #(.W(COEF_AW)) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (beat_load),
        .load_val (beat_init),
        .en       (beat_en),
        .tc       (beat_tc)
    );

    svm_beat_counter #(.W(TO_W)) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT - 1)),
        .en       (to_en),
        .tc       (to_tc)
    );

    // Job sequencing; ROM addresses run one beat ahead of the strobes to cover the ROM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            cls_start   <= 1'b0;
            write1      <= 1'b0;
            write2      <= 1'b0;
            done        <= 1'b0;
            result_q    <= 1'b0;
            err_timeout <= 1'b0;
            coef_addr   <= '0;
            feat_addr   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                cls_start <= 1'b0;
                write1    <= 1'b0;
                write2    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (go) begin
                            err_timeout <= 1'b0;
                            busy        <= 1'b1;
                            cls_start   <= 1'b1;
                            coef_addr   <= '0;
                            state       <= PREF;
                        end
                    end
                    PREF: begin
                        coef_addr <= COEF_AW'(1);
                        write1    <= 1'b1;
                        state     <= LOAD_COEF;
                    end
                    LOAD_COEF: begin
                        if (coef_addr != COEF_LAST) begin
                            coef_addr <= coef_addr + 1'b1;
                        end
                        if (beat_tc) begin
                            write1    <= 1'b0;
                            write2    <= 1'b1;
                            feat_addr <= (FEAT_LAST != '0) ? FEAT_AW'(1) : '0;
                            state     <= LOAD_FEAT;
                        end else if (coef_addr == COEF_LAST) begin
                            // Feature 0 must be on the ROM address during the last coef beat.
                            feat_addr <= '0;
                        end
                    end
                    LOAD_FEAT: begin
                        if (feat_addr != FEAT_LAST) begin
                            feat_addr <= feat_addr + 1'b1;
                        end
                        if (beat_tc) begin
                            write2 <= 1'b0;
                            state  <= WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        if (cls_ready) begin
                            result_q  <= cls_result;
                            cls_start <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (to_tc) begin
                            err_timeout <= 1'b1;
                            cls_start   <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Last delivered beat is held so the classifier inputs stay stable between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            svm_hold  <= '0;
            feat_hold <= '0;
        end else begin
            if (write1) svm_hold  <= coef_data;
            if (write2) feat_hold <= feat_data;
        end
    end

    assign svm_out  = write1 ? coef_data : svm_hold;
    assign data_out = write2 ? feat_data : feat_hold;

endmodule

// File: tb/tb_svm_load_sequencer.sv
// Directed bench: nominal job, reset, abort, ignored go, timeout (second instance) and back-to-back.
// Latency: n/a.
// Backpressure: n/a.
module tb_svm_load_sequencer;
    import svm_pkg::*;

    logic clk, rst, go, abort, cls_ready, cls_result;
    logic [COEF_AW-1:0] coef_addr;
    logic [FEAT_AW-1:0] feat_addr;
    logic signed [COEF_W-1:0] coef_data, svm_out;
    logic signed [FEAT_W-1:0] feat_data, data_out;
    logic cls_start, write1, write2, busy, done, result_q, err_timeout;

    logic t_go, t_abort, t_ready, t_result;
    logic [COEF_AW-1:0] t_coef_addr;
    logic [FEAT_AW-1:0] t_feat_addr;
    logic signed [COEF_W-1:0] t_coef_data, t_svm_out;
    logic signed [FEAT_W-1:0] t_feat_data, t_data_out;
    logic t_cls_start, t_write1, t_write2, t_busy, t_done, t_result_q, t_err;

    int checks = 0;
    int failures = 0;

    svm_load_sequencer u_dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .coef_addr(coef_addr), .coef_data(coef_data), .feat_addr(feat_addr), .feat_data(feat_data),
        .cls_start(cls_start), .write1(write1), .svm_out(svm_out), .write2(write2), .data_out(data_out),
        .cls_ready(cls_ready), .cls_result(cls_result), .busy(busy), .done(done),
        .result_q(result_q), .err_timeout(err_timeout)
    );

    svm_load_sequencer #(.TIMEOUT(16)) u_dut_t (
        .clk(clk), .rst(rst), .go(t_go), .abort(t_abort),
        .coef_addr(t_coef_addr), .coef_data(t_coef_data), .feat_addr(t_feat_addr), .feat_data(t_feat_data),
        .cls_start(t_cls_start), .write1(t_write1), .svm_out(t_svm_out), .write2(t_write2), .data_out(t_data_out),
        .cls_ready(t_ready), .cls_result(t_result), .busy(t_busy), .done(t_done),
        .result_q(t_result_q), .err_timeout(t_err)
    );

    function automatic logic signed [COEF_W-1:0] coef_val(input int k);
        return COEF_W'(k - 60);
    endfunction

    function automatic logic signed [FEAT_W-1:0] feat_val(input int k);
        return FEAT_W'((k % 4) - 2);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM models with one cycle of read latency
    always @(posedge clk) begin
        coef_data   <= coef_val(int'(coef_addr));
        feat_data   <= feat_val(int'(feat_addr));
        t_coef_data <= coef_val(int'(t_coef_addr));
        t_feat_data <= feat_val(int'(t_feat_addr));
    end

    // Stream monitor for the main instance: beat counts, beat values, overlap, gap, run lengths
    int w1_tot = 0, w2_tot = 0, done_tot = 0, both_tot = 0;
    int val1_bad = 0, val2_bad = 0, gap_bad = 0, len1_bad = 0, len2_bad = 0;
    int w1_run = 0, w2_run = 0;
    logic prev_w1 = 1'b0;

    always @(negedge clk) begin
        if (write1 && write2) both_tot <= both_tot + 1;
        if (done) done_tot <= done_tot + 1;
        if (write1) begin
            if (svm_out !== coef_val(w1_run)) val1_bad <= val1_bad + 1;
            w1_run <= w1_run + 1;
            w1_tot <= w1_tot + 1;
        end else begin
            if (w1_run != 0 && w1_run != N_COEF) len1_bad <= len1_bad + 1;
            w1_run <= 0;
        end
        if (write2) begin
            if (data_out !== feat_val(w2_run)) val2_bad <= val2_bad + 1;
            if (w2_run == 0 && !prev_w1) gap_bad <= gap_bad + 1;
            w2_run <= w2_run + 1;
            w2_tot <= w2_tot + 1;
        end else begin
            if (w2_run != 0 && w2_run != N_FEAT) len2_bad <= len2_bad + 1;
            w2_run <= 0;
        end
        prev_w1 <= write1;
    end

    function automatic int stream_errs();
        return val1_bad + val2_bad + gap_bad + len1_bad + len2_bad + both_tot;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Returns on the first cycle after the last write2 beat
    task automatic wait_load_end(output bit ok);
        bit seen;
        seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (write2) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0; go = 1'b0; abort = 1'b0; cls_ready = 1'b0; cls_result = 1'b0;
        t_go = 1'b0; t_abort = 1'b0; t_ready = 1'b0; t_result = 1'b0;
        tick(); tick();
        checks++; if ({busy, done, cls_start, write1, write2, result_q, err_timeout} !== 7'b0) begin failures++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, cls_start, write1, write2, result_q, err_timeout}); end
        checks++; if ({coef_addr, feat_addr, svm_out, data_out} !== '0) begin failures++; $display("FAIL reset_buses: got %h want 0", {coef_addr, feat_addr, svm_out, data_out}); end
        rst = 1'b1;
        tick();
        go = 1'b1; tick(); go = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && n < 50; i++) begin
            tick();
            if (write1) n++;
        end
        checks++; if (n != 50) begin failures++; $display("FAIL reset_reach_beat50: got %0d beats want 50", n); end
        rst = 1'b0;
        #1;
        checks++; if ({busy, cls_start, write1, coef_addr, svm_out} !== '0) begin failures++; $display("FAIL reset_async: got %h want 0", {busy, cls_start, write1, coef_addr, svm_out}); end
        tick();
        rst = 1'b1;
        tick();
        go = 1'b1; tick(); go = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !write1; i++) begin
            tick();
            n++;
        end
        checks++; if (n != 1) begin failures++; $display("FAIL reset_restart_latency: got %0d cycles want 1", n); end
        checks++; if (svm_out !== coef_val(0)) begin failures++; $display("FAIL reset_restart_coef0: got %0d want %0d", svm_out, coef_val(0)); end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++; if ({busy, write1, cls_start} !== 3'b000) begin failures++; $display("FAIL reset_abort_idle: got %b want 000", {busy, write1, cls_start}); end
    endtask

    task automatic test_abort_vs_ready();
        bit ok;
        int s_done;
        s_done = done_tot;
        go = 1'b1; tick(); go = 1'b0;
        wait_load_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_load_end: got no end of load want end within bound"); end
        tick(); tick();
        abort = 1'b1; cls_ready = 1'b1; cls_result = 1'b1;
        tick();
        abort = 1'b0; cls_ready = 1'b0; cls_result = 1'b0;
        checks++; if ({busy, cls_start, write1, write2, done} !== 5'b0) begin failures++; $display("FAIL abort_idle: got %b want 00000", {busy, cls_start, write1, write2, done}); end
        checks++; if (result_q !== 1'b0) begin failures++; $display("FAIL abort_result_q: got %b want 0", result_q); end
        repeat (5) tick();
        checks++; if (done_tot - s_done != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", done_tot - s_done); end
    endtask

    task automatic test_nominal();
        bit ok;
        int s_w1, s_w2, s_done, s_err;
        s_w1 = w1_tot; s_w2 = w2_tot; s_done = done_tot; s_err = stream_errs();
        go = 1'b1; tick(); go = 1'b0;
        tick();
        checks++; if ({write1, cls_start, busy} !== 3'b111) begin failures++; $display("FAIL nom_beat0_flags: got %b want 111", {write1, cls_start, busy}); end
        checks++; if (coef_addr !== 7'd1) begin failures++; $display("FAIL nom_beat0_addr: got %0d want 1", coef_addr); end
        wait_load_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL nom_load_end: got no end of load want end within bound"); end
        repeat (19) tick();
        cls_ready = 1'b1; cls_result = 1'b1;
        wait_done(ok);
        cls_ready = 1'b0; cls_result = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL nom_done_seen: got no done want done"); end
        checks++; if ({result_q, cls_start} !== 2'b10) begin failures++; $display("FAIL nom_done_state: got result_q,cls_start=%b want 10", {result_q, cls_start}); end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL nom_after_done: got busy,done=%b want 00", {busy, done}); end
        checks++; if (w1_tot - s_w1 != N_COEF) begin failures++; $display("FAIL nom_write1_beats: got %0d want %0d", w1_tot - s_w1, N_COEF); end
        checks++; if (w2_tot - s_w2 != N_FEAT) begin failures++; $display("FAIL nom_write2_beats: got %0d want %0d", w2_tot - s_w2, N_FEAT); end
        checks++; if (stream_errs() - s_err != 0) begin failures++; $display("FAIL nom_stream: got %0d value/gap/overlap errors want 0", stream_errs() - s_err); end
        checks++; if (done_tot - s_done != 1) begin failures++; $display("FAIL nom_done_count: got %0d want 1", done_tot - s_done); end
    endtask

    task automatic test_go_ignored();
        bit ok;
        int s_w1, s_w2, s_done;
        s_w1 = w1_tot; s_w2 = w2_tot; s_done = done_tot;
        go = 1'b1; tick(); go = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (write2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL goign_feat_phase: got no write2 want write2"); end
        tick();
        go = 1'b1; tick(); go = 1'b0;
        wait_load_end(ok);
        checks++; if (!ok) begin failures++; $display("FAIL goign_load_end: got no end of load want end within bound"); end
        repeat (3) tick();
        cls_ready = 1'b1; cls_result = 1'b0;
        wait_done(ok);
        cls_ready = 1'b0;
        go = 1'b1;
        checks++; if (!ok) begin failures++; $display("FAIL goign_done_seen: got no done want done"); end
        tick();
        go = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL goign_done_go: got busy=%b want 0", busy); end
        repeat (4) tick();
        checks++; if ({busy, write1} !== 2'b00) begin failures++; $display("FAIL goign_no_restart: got busy,write1=%b want 00", {busy, write1}); end
        checks++; if (w1_tot - s_w1 != N_COEF || w2_tot - s_w2 != N_FEAT) begin failures++; $display("FAIL goign_beats: got %0d/%0d want %0d/%0d", w1_tot - s_w1, w2_tot - s_w2, N_COEF, N_FEAT); end
        checks++; if (done_tot - s_done != 1) begin failures++; $display("FAIL goign_done_count: got %0d want 1", done_tot - s_done); end
        checks++; if (result_q !== 1'b0) begin failures++; $display("FAIL goign_result_q: got %b want 0", result_q); end
    endtask

    task automatic test_timeout();
        bit ok, seen;
        int n;
        t_go = 1'b1; tick(); t_go = 1'b0;
        ok = 1'b0; seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (t_write2) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL to_load_end: got no end of load want end within bound"); end
        checks++; if ({t_err, t_busy} !== 2'b01) begin failures++; $display("FAIL to_wait_entry: got err,busy=%b want 01", {t_err, t_busy}); end
        n = 0; ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            n++;
            if (t_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok || n != 16) begin failures++; $display("FAIL to_done_delay: got %0d cycles (seen=%b) want 16", n, ok); end
        checks++; if ({t_err, t_result_q} !== 2'b10) begin failures++; $display("FAIL to_flags: got err,result_q=%b want 10", {t_err, t_result_q}); end
        tick();
        checks++; if ({t_busy, t_err} !== 2'b01) begin failures++; $display("FAIL to_sticky: got busy,err=%b want 01", {t_busy, t_err}); end
        t_go = 1'b1; tick(); t_go = 1'b0;
        checks++; if ({t_err, t_busy} !== 2'b01) begin failures++; $display("FAIL to_clear_on_go: got err,busy=%b want 01", {t_err, t_busy}); end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (t_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL to_second_job: got no done want done"); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s_w1, s_w2, s_done, s_err;
        s_w1 = w1_tot; s_w2 = w2_tot; s_done = done_tot; s_err = stream_errs();
        go = 1'b1;
        for (int j = 0; j < 2; j++) begin
            wait_load_end(ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_load_end_%0d: got no end of load want end within bound", j); end
            repeat (2) tick();
            cls_ready = 1'b1; cls_result = (j == 0);
            wait_done(ok);
            cls_ready = 1'b0;
            checks++; if (!ok || result_q !== 1'(j == 0)) begin failures++; $display("FAIL b2b_done_%0d: got done_seen=%b result_q=%b want 1 %b", j, ok, result_q, 1'(j == 0)); end
            if (j == 0) begin
                tick();
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy); end
                tick();
                checks++; if ({busy, cls_start, write1} !== 3'b110) begin failures++; $display("FAIL b2b_restart: got busy,cls_start,write1=%b want 110", {busy, cls_start, write1}); end
            end else begin
                go = 1'b0;
            end
        end
        repeat (4) tick();
        checks++; if (w1_tot - s_w1 != 2 * N_COEF || w2_tot - s_w2 != 2 * N_FEAT) begin failures++; $display("FAIL b2b_beats: got %0d/%0d want %0d/%0d", w1_tot - s_w1, w2_tot - s_w2, 2 * N_COEF, 2 * N_FEAT); end
        checks++; if (stream_errs() - s_err != 0) begin failures++; $display("FAIL b2b_stream: got %0d value/gap/overlap errors want 0", stream_errs() - s_err); end
        checks++; if (done_tot - s_done != 2 || busy !== 1'b0) begin failures++; $display("FAIL b2b_done_count: got %0d pulses busy=%b want 2 0", done_tot - s_done, busy); end
    endtask

    initial begin
        test_reset();
        test_abort_vs_ready();
        test_nominal();
        test_go_ignored();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
